// File: rtl/wb_rep_sequencer_pkg.sv
// rtl/wb_rep_sequencer_pkg.sv - shared writeback encodings for the string-repeat sequencer
package wb_rep_sequencer_pkg;

  typedef enum logic [1:0] {
    REP_NONE  = 2'b00,
    REP_REP   = 2'b01,
    REP_REPE  = 2'b10,
    REP_REPNE = 2'b11
  } rep_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ITER   = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

endpackage

// File: rtl/wb_rep_sequencer_stop_eval.sv
// rtl/wb_rep_sequencer_stop_eval.sv - combinational end-of-string decision for one iteration
module wb_rep_stop_eval
  import wb_rep_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic [1:0]       rep_mode,
  input  logic             zf,
  input  logic [CNT_W-1:0] count,
  output logic             stop
);

  rep_mode_e mode;
  assign mode = rep_mode_e'(rep_mode);

  // Zero test spans the full count so a wrapped all-ones count keeps repeating.
  assign stop = (mode == REP_NONE)
              | (count == '0)
              | ((mode == REP_REPE)  & ~zf)
              | ((mode == REP_REPNE) &  zf);

endmodule

// File: rtl/wb_rep_sequencer.sv
// rtl/wb_rep_sequencer.sv - writeback-stage sequencer for REP/REPE/REPNE string instructions
module wb_rep_sequencer
  import wb_rep_sequencer_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int PTR_W  = 32,
  parameter int ITER_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WB_V,
  input  logic              UOP_FIRST,
  input  logic              UOP_LAST,
  input  logic [1:0]        REP_MODE,
  input  logic              ZF,
  input  logic [CNT_W-1:0]  WB_RESULT_C,
  input  logic [PTR_W-1:0]  WB_RESULT_A,
  input  logic              IS_HALT,
  output logic [PTR_W-1:0]  saved_ptr,
  output logic              repeat_all,
  output logic              terminate_all,
  output logic              halt_all,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_d;
  logic [ITER_W-1:0] iter_base, iter_d;
  logic              rep_d, term_d, halt_d;
  logic              take_last;
  logic              stop;

  wb_rep_stop_eval #(.CNT_W(CNT_W)) u_stop_eval (
    .rep_mode (REP_MODE),
    .zf       (ZF),
    .count    (WB_RESULT_C),
    .stop     (stop)
  );

  // The count of the finished instruction is visible during its terminate pulse, then drops.
  assign iter_base = terminate_all ? '0 : iter_cnt;
  assign busy      = (state_q == ST_ITER);

  always_comb begin
    state_d   = state_q;
    ptr_d     = saved_ptr;
    iter_d    = iter_base;
    rep_d     = 1'b0;
    term_d    = 1'b0;
    halt_d    = halt_all;
    take_last = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (WB_V && IS_HALT) begin
          state_d = ST_HALTED;
          halt_d  = 1'b1;
        end else if (WB_V && UOP_FIRST) begin
          ptr_d     = WB_RESULT_A;
          state_d   = ST_ITER;
          take_last = UOP_LAST;
        end
      end
      ST_ITER: begin
        if (WB_V && IS_HALT) begin
          state_d = ST_HALTED;
          halt_d  = 1'b1;
        end else begin
          if (WB_V && UOP_FIRST) ptr_d = WB_RESULT_A;
          take_last = WB_V && UOP_LAST;
        end
      end
      ST_HALTED: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_last) begin
      iter_d = (iter_base == '1) ? iter_base : iter_base + ITER_W'(1);
      if (stop) begin
        term_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        rep_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      saved_ptr     <= '0;
      iter_cnt      <= '0;
      repeat_all    <= 1'b0;
      terminate_all <= 1'b0;
      halt_all      <= 1'b0;
    end else begin
      state_q       <= state_d;
      saved_ptr     <= ptr_d;
      iter_cnt      <= iter_d;
      repeat_all    <= rep_d;
      terminate_all <= term_d;
      halt_all      <= halt_d;
    end
  end

endmodule
